// File: rtl/video_timing_pkg.sv
// Shared timing defaults (5 MHz board profile) and the wrap-aware window compare
// used by the raster decoders.
package video_timing_pkg;

  localparam int unsigned VT_H_W       = 9;
  localparam int unsigned VT_H_LOAD    = 'h0C0;
  localparam int unsigned VT_H_LAST    = 'h1FF;
  localparam int unsigned VT_V_W       = 9;
  localparam int unsigned VT_V_LOAD    = 'h0F8;
  localparam int unsigned VT_V_LAST    = 'h1FF;
  localparam int unsigned VT_HS_BEG    = 'h10A;
  localparam int unsigned VT_HS_END    = 'h121;
  localparam int unsigned VT_HSF_BEG   = 'h11E;
  localparam int unsigned VT_HSF_END   = 'h135;
  localparam int unsigned VT_HB_BEG    = 'h0C0;
  localparam int unsigned VT_HB_END    = 'h0FF;
  localparam int unsigned VT_VS_BEG    = 'h1F0;
  localparam int unsigned VT_VS_END    = 'h1F7;
  localparam int unsigned VT_VB_BEG    = 'h1F0;
  localparam int unsigned VT_VB_END    = 'h10F;
  localparam int unsigned VT_CPU_SLOT  = 'h11F;
  localparam int unsigned VT_CPU_SLOTF = 'h137;
  localparam int unsigned VT_SER_SH    = 3;
  localparam int unsigned VT_SER_PH    = 6;

  // Inclusive window a..b; when a > b the window wraps through the counter preset.
  function automatic logic in_range(input logic [15:0] x,
                                    input logic [15:0] a,
                                    input logic [15:0] b);
    if (a <= b) return (x >= a) && (x <= b);
    else        return (x >= a) || (x <= b);
  endfunction

endpackage

// File: rtl/video_timing_gen_counter.sv
// Raster counter with synchronous preset on terminal count. The next-state value
// is exported so the decoders can register outputs aligned with the count.
module vt_counter #(
  parameter int unsigned  W    = 9,
  parameter logic [W-1:0] LOAD = '0,
  parameter logic [W-1:0] LAST = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  output logic [W-1:0] cnt_q,
  output logic [W-1:0] cnt_d,
  output logic         tc
);

  assign tc = (cnt_q == LAST);

  // Next count: hold, preset after terminal count, or increment.
  always_comb begin
    cnt_d = cnt_q;
    if (ce) cnt_d = tc ? LOAD : cnt_q + W'(1);
  end

  // Count register; reset lands on the preset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= LOAD;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing root: H/V counters, sync/blank windows, line/frame, CPU slot and
// serializer load strobes, with a frame-synchronous screen flip.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned      H_W        = VT_H_W,
  parameter logic [H_W-1:0]   H_LOAD     = H_W'(VT_H_LOAD),
  parameter logic [H_W-1:0]   H_LAST     = H_W'(VT_H_LAST),
  parameter int unsigned      V_W        = VT_V_W,
  parameter logic [V_W-1:0]   V_LOAD     = V_W'(VT_V_LOAD),
  parameter logic [V_W-1:0]   V_LAST     = V_W'(VT_V_LAST),
  parameter logic [H_W-1:0]   HS_BEG     = H_W'(VT_HS_BEG),
  parameter logic [H_W-1:0]   HS_END     = H_W'(VT_HS_END),
  parameter logic [H_W-1:0]   HSF_BEG    = H_W'(VT_HSF_BEG),
  parameter logic [H_W-1:0]   HSF_END    = H_W'(VT_HSF_END),
  parameter logic [H_W-1:0]   HB_BEG     = H_W'(VT_HB_BEG),
  parameter logic [H_W-1:0]   HB_END     = H_W'(VT_HB_END),
  parameter logic [V_W-1:0]   VS_BEG     = V_W'(VT_VS_BEG),
  parameter logic [V_W-1:0]   VS_END     = V_W'(VT_VS_END),
  parameter logic [V_W-1:0]   VB_BEG     = V_W'(VT_VB_BEG),
  parameter logic [V_W-1:0]   VB_END     = V_W'(VT_VB_END),
  parameter logic [H_W-1:0]   CPU_SLOT   = H_W'(VT_CPU_SLOT),
  parameter logic [H_W-1:0]   CPU_SLOT_F = H_W'(VT_CPU_SLOTF),
  parameter int unsigned      SER_SH     = VT_SER_SH,
  parameter int unsigned      SER_PH     = VT_SER_PH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pix_ce,
  input  logic           flip_req,
  output logic [H_W-1:0] h,
  output logic [V_W-1:0] v,
  output logic [H_W-1:0] h_flip,
  output logic           flip,
  output logic           hsync_n,
  output logic           vsync_n,
  output logic           hblank,
  output logic           vblank,
  output logic           line_start,
  output logic           frame_start,
  output logic           cpu_slot,
  output logic           ser_load
);

  localparam logic [SER_SH-1:0] SER_PHASE = SER_SH'(SER_PH);

  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;
  logic           h_tc, v_tc;
  logic           flip_q, flip_d;
  logic           hsync_n_q, vsync_n_q, hblank_q, vblank_q;
  logic           line_start_q, frame_start_q, cpu_slot_q, ser_load_q;
  logic           hsync_n_d, vsync_n_d, hblank_d, vblank_d;
  logic           line_start_d, frame_start_d, cpu_slot_d, ser_load_d;

  vt_counter #(.W(H_W), .LOAD(H_LOAD), .LAST(H_LAST)) u_hcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (pix_ce),
    .cnt_q (h_q),
    .cnt_d (h_d),
    .tc    (h_tc)
  );

  vt_counter #(.W(V_W), .LOAD(V_LOAD), .LAST(V_LAST)) u_vcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (pix_ce & h_tc),
    .cnt_q (v_q),
    .cnt_d (v_d),
    .tc    (v_tc)
  );

  // Flip is only taken at the frame boundary so a frame is never half mirrored.
  always_comb begin
    flip_d = flip_q;
    if (pix_ce && h_tc && v_tc) flip_d = flip_req;
  end

  // Decode windows from the next count/flip so registered outputs line up with h/v.
  always_comb begin
    hsync_n_d     = 1'b1;
    vsync_n_d     = 1'b1;
    hblank_d      = 1'b0;
    vblank_d      = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    cpu_slot_d    = 1'b0;
    ser_load_d    = 1'b0;
    if (flip_d) hsync_n_d = ~in_range(16'(h_d), 16'(HSF_BEG), 16'(HSF_END));
    else        hsync_n_d = ~in_range(16'(h_d), 16'(HS_BEG), 16'(HS_END));
    vsync_n_d     = ~in_range(16'(v_d), 16'(VS_BEG), 16'(VS_END));
    hblank_d      = in_range(16'(h_d), 16'(HB_BEG), 16'(HB_END));
    vblank_d      = in_range(16'(v_d), 16'(VB_BEG), 16'(VB_END));
    line_start_d  = (h_d == H_LOAD);
    frame_start_d = (h_d == H_LOAD) && (v_d == V_LOAD);
    cpu_slot_d    = (h_d == (flip_d ? CPU_SLOT_F : CPU_SLOT));
    ser_load_d    = (h_d[SER_SH-1:0] == (flip_d ? ~SER_PHASE : SER_PHASE));
  end

  // Output registers advance only with the pixel enable, so pulses last one pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flip_q        <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      cpu_slot_q    <= 1'b0;
      ser_load_q    <= 1'b0;
    end else if (pix_ce) begin
      flip_q        <= flip_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      cpu_slot_q    <= cpu_slot_d;
      ser_load_q    <= ser_load_d;
    end
  end

  assign h           = h_q;
  assign v           = v_q;
  assign h_flip      = h_q ^ {H_W{flip_q}};
  assign flip        = flip_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign cpu_slot    = cpu_slot_q;
  assign ser_load    = ser_load_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: an independent raster model pushes the expected
// outputs for every clock into a queue; each clock the DUT outputs are popped and
// compared. The frame is shortened (V_LOAD=1E0, 32 lines) to keep runs short;
// every other timing value is the board default.
module tb_video_timing_gen;

  localparam int V_LOAD_TB = 'h1E0;

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] v;
    logic [8:0] h_flip;
    logic       flip;
    logic       hsync_n;
    logic       vsync_n;
    logic       hblank;
    logic       vblank;
    logic       line_start;
    logic       frame_start;
    logic       cpu_slot;
    logic       ser_load;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n, pix_ce, flip_req;
  logic [8:0] h, v, h_flip;
  logic       flip, hsync_n, vsync_n, hblank, vblank;
  logic       line_start, frame_start, cpu_slot, ser_load;

  int   total = 0;
  int   bad = 0;
  obs_t sb_q[$];
  obs_t cur_exp;
  obs_t rst_exp;
  int   mh, mv, mflip;

  int   n_ls, n_fs, n_hs, hs_first, n_cpu, cpu_h, n_ser, n_hb, n_vs_lines, n_vb_lines;

  video_timing_gen #(.V_LOAD(9'h1E0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_ce      (pix_ce),
    .flip_req    (flip_req),
    .h           (h),
    .v           (v),
    .h_flip      (h_flip),
    .flip        (flip),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .hblank      (hblank),
    .vblank      (vblank),
    .line_start  (line_start),
    .frame_start (frame_start),
    .cpu_slot    (cpu_slot),
    .ser_load    (ser_load)
  );

  always #5 clk = ~clk;

  function automatic obs_t reset_values();
    obs_t e;
    e.h = 9'h0C0; e.v = 9'h1E0; e.h_flip = 9'h0C0; e.flip = 1'b0;
    e.hsync_n = 1'b1; e.vsync_n = 1'b1; e.hblank = 1'b0; e.vblank = 1'b0;
    e.line_start = 1'b0; e.frame_start = 1'b0; e.cpu_slot = 1'b0; e.ser_load = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    mh = 'h0C0; mv = V_LOAD_TB; mflip = 0;
    cur_exp = reset_values();
  endtask

  // One pixel of the reference raster.
  task automatic model_step();
    logic [8:0] hv;
    if (mh == 'h1FF) begin
      mh = 'h0C0;
      if (mv == 'h1FF) begin
        mv = V_LOAD_TB;
        mflip = int'(flip_req);
      end else mv = mv + 1;
    end else mh = mh + 1;
    hv = mh[8:0];
    cur_exp.h = hv;
    cur_exp.v = mv[8:0];
    cur_exp.flip = (mflip != 0);
    cur_exp.h_flip = (mflip != 0) ? (9'h1FF - hv) : hv;
    if (mflip != 0) cur_exp.hsync_n = !(mh >= 'h11E && mh <= 'h135);
    else            cur_exp.hsync_n = !(mh >= 'h10A && mh <= 'h121);
    cur_exp.vsync_n = !(mv >= 'h1F0 && mv <= 'h1F7);
    cur_exp.hblank = (mh >= 'h0C0 && mh <= 'h0FF);
    cur_exp.vblank = (mv >= 'h1F0) || (mv <= 'h10F);
    cur_exp.line_start = (mh == 'h0C0);
    cur_exp.frame_start = (mh == 'h0C0) && (mv == V_LOAD_TB);
    cur_exp.cpu_slot = (mh == ((mflip != 0) ? 'h137 : 'h11F));
    cur_exp.ser_load = ((mh % 8) == ((mflip != 0) ? 1 : 6));
  endtask

  task automatic check(input string tag);
    obs_t e, a;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    a.h = h; a.v = v; a.h_flip = h_flip; a.flip = flip;
    a.hsync_n = hsync_n; a.vsync_n = vsync_n; a.hblank = hblank; a.vblank = vblank;
    a.line_start = line_start; a.frame_start = frame_start;
    a.cpu_slot = cpu_slot; a.ser_load = ser_load;
    assert (a === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (h=%h v=%h exp h=%h v=%h)",
             tag, a, e, a.h, a.v, e.h, e.v);
    end
  endtask

  task automatic expect_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_ls = 0; n_fs = 0; n_hs = 0; hs_first = -1; n_cpu = 0; cpu_h = -1;
    n_ser = 0; n_hb = 0; n_vs_lines = 0; n_vb_lines = 0;
  endtask

  // Drive one clock (inputs set #1 after the edge), then check the popped expectation.
  task automatic tick(input logic ce);
    pix_ce = ce;
    if (ce) model_step();
    sb_q.push_back(cur_exp);
    @(posedge clk);
    #1;
    check("cycle");
    if (line_start) n_ls++;
    if (frame_start) n_fs++;
    if (!hsync_n) begin
      n_hs++;
      if (hs_first < 0) hs_first = int'(h);
    end
    if (cpu_slot) begin n_cpu++; cpu_h = int'(h); end
    if (ser_load) n_ser++;
    if (hblank) n_hb++;
    if (line_start && !vsync_n) n_vs_lines++;
    if (line_start && vblank) n_vb_lines++;
  endtask

  initial begin
    int guard;
    rst_n = 1'b1; pix_ce = 1'b0; flip_req = 1'b0;
    rst_exp = reset_values();
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb_q.push_back(rst_exp);
    check("reset");
    pix_ce = 1'b1;
    @(posedge clk);
    #1;
    sb_q.push_back(rst_exp);
    check("reset_with_ce");

    rst_n = 1'b1;
    model_reset();
    tick(1'b0);
    tick(1'b0);

    // First line, unflipped.
    clear_counts();
    repeat (320) tick(1'b1);
    expect_int("line_start_per_line", n_ls, 1);
    expect_int("h_back_to_load", int'(h), 'h0C0);
    expect_int("hsync_low_px", n_hs, 24);
    expect_int("hsync_first_h", hs_first, 'h10A);
    expect_int("cpu_slot_count", n_cpu, 1);
    expect_int("cpu_slot_h", cpu_h, 'h11F);
    expect_int("ser_load_per_line", n_ser, 40);
    expect_int("hblank_px", n_hb, 64);

    // Rest of the frame; flip requested mid-frame must wait for the boundary.
    n_fs = 0; n_vs_lines = 0; n_vb_lines = 0;
    repeat (4680) tick(1'b1);
    flip_req = 1'b1;
    repeat (5239) tick(1'b1);
    expect_int("flip_held_midframe", int'(flip), 0);
    expect_int("frame_start_before_wrap", n_fs, 0);
    tick(1'b1);
    expect_int("flip_at_boundary", int'(flip), 1);
    expect_int("frame_start_count", n_fs, 1);
    expect_int("v_back_to_load", int'(v), V_LOAD_TB);
    expect_int("vsync_lines", n_vs_lines, 8);
    expect_int("vblank_lines", n_vb_lines, 16);

    // Flipped line.
    clear_counts();
    repeat (320) tick(1'b1);
    expect_int("flip_hsync_low_px", n_hs, 24);
    expect_int("flip_hsync_first_h", hs_first, 'h11E);
    expect_int("flip_cpu_slot_h", cpu_h, 'h137);
    expect_int("flip_ser_load_per_line", n_ser, 40);
    expect_int("h_flip_is_inverse", int'(h_flip), int'(~h) & 'h1FF);

    // Pixel enable one clock in four: each pulse spans four clocks.
    clear_counts();
    for (int i = 0; i < 200; i++) begin
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
      tick(1'b0);
    end
    expect_int("ce4_ser_load_clocks", n_ser, 100);
    expect_int("ce4_h_advanced", int'(h), 'h188);

    // Walk to h=150, v=1E4, then pull reset between clock edges.
    guard = 0;
    while (!(mh == 'h150 && mv == 'h1E4) && guard < 12000) begin
      tick(1'b1);
      guard++;
    end
    expect_int("reach_reset_point", int'(guard < 12000), 1);
    #3;
    rst_n = 1'b0;
    #1;
    sb_q.push_back(rst_exp);
    check("async_reset_midframe");
    @(posedge clk);
    #1;
    sb_q.push_back(rst_exp);
    check("reset_held");
    rst_n = 1'b1;
    model_reset();
    clear_counts();
    repeat (330) tick(1'b1);
    expect_int("restart_line_start", n_ls, 1);
    expect_int("restart_v", int'(v), V_LOAD_TB + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
